// File: rtl/issue_scoreboard.sv
// Issue scoreboard: per-register busy tracking, hazard check and one-hot unit issue.
// Optional macro SCB_FREE_BYPASS_EN lets same-cycle frees mask busy bits in the hazard check.
module issue_scoreboard #(
  parameter int NUM_REGS    = 64,
  parameter int RN_W        = 6,
  parameter int NUM_UNITS   = 5,
  parameter int UNIT_W      = 3,
  parameter int NUM_FREE    = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [UNIT_W-1:0]        in_unit,
  input  logic [RN_W-1:0]          in_rs1_rn,
  input  logic [RN_W-1:0]          in_rs2_rn,
  input  logic                     in_rs1_use,
  input  logic                     in_rs2_use,
  input  logic [RN_W-1:0]          in_rd_rn,
  input  logic [RN_W-1:0]          in_rd2_rn,
  input  logic                     in_rd_we,
  input  logic                     in_rd2_we,
  input  logic [NUM_UNITS-1:0]     unit_busy,
  output logic [NUM_UNITS-1:0]     unit_en,
  output logic [RN_W-1:0]          rd_out_rn,
  output logic [RN_W-1:0]          rd2_out_rn,
  input  logic [NUM_FREE*RN_W-1:0] free_rn,
  input  logic [NUM_FREE-1:0]      free_en,
  input  logic                     flush,
  output logic [NUM_REGS-1:0]      reg_busy,
  output logic [STALL_CNT_W-1:0]   stall_cnt
);

  // Handshake: an instruction issues on a cycle where in_valid && in_ready;
  // in_ready never looks at in_valid, and decode must hold the instruction until it issues.

  logic [NUM_REGS-1:0]  free_mask;
  logic [NUM_REGS-1:0]  set_mask;
  logic [NUM_REGS-1:0]  busy_view;
  logic [NUM_REGS-1:0]  busy_next;
  logic [NUM_UNITS-1:0] unit_en_next;
  logic                 raw_hazard;
  logic                 waw_hazard;
  logic                 unit_hazard;
  logic                 illegal_unit;
  logic                 dup_dest;
  logic                 issue;
  logic                 stall_inc;

  always_comb begin
    free_mask = '0;
    for (int k = 0; k < NUM_FREE; k++) begin
      if (free_en[k]) free_mask[free_rn[k*RN_W +: RN_W]] = 1'b1;
    end
  end

`ifdef SCB_FREE_BYPASS_EN
  assign busy_view = reg_busy & ~free_mask;
`else
  assign busy_view = reg_busy;
`endif

  // Register 0 is never busy, so it can never raise RAW or WAW.
  always_comb begin
    raw_hazard   = (in_rs1_use && (in_rs1_rn != '0) && busy_view[in_rs1_rn]) ||
                   (in_rs2_use && (in_rs2_rn != '0) && busy_view[in_rs2_rn]);
    waw_hazard   = (in_rd_we  && (in_rd_rn  != '0) && busy_view[in_rd_rn]) ||
                   (in_rd2_we && (in_rd2_rn != '0) && busy_view[in_rd2_rn]);
    dup_dest     = in_rd_we && in_rd2_we && (in_rd_rn == in_rd2_rn) && (in_rd_rn != '0);
    illegal_unit = 32'(in_unit) >= NUM_UNITS;
    unit_hazard  = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (32'(in_unit) == u) unit_hazard = unit_busy[u];
    end
  end

  assign in_ready  = !(raw_hazard || waw_hazard || dup_dest || illegal_unit || unit_hazard) && !flush;
  assign issue     = in_valid && in_ready;
  assign stall_inc = in_valid && !in_ready && !flush;

  always_comb begin
    set_mask = '0;
    if (issue && in_rd_we)  set_mask[in_rd_rn]  = 1'b1;
    if (issue && in_rd2_we) set_mask[in_rd2_rn] = 1'b1;
    // Set wins over a same-cycle free: the register belongs to the new writer.
    busy_next    = (reg_busy & ~free_mask) | set_mask;
    busy_next[0] = 1'b0;
    unit_en_next = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      unit_en_next[u] = issue && (32'(in_unit) == u);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_busy   <= '0;
      unit_en    <= '0;
      rd_out_rn  <= '0;
      rd2_out_rn <= '0;
      stall_cnt  <= '0;
    end else begin
      reg_busy <= busy_next;
      unit_en  <= unit_en_next;
      if (issue) begin
        rd_out_rn  <= in_rd_rn;
        rd2_out_rn <= in_rd2_rn;
      end
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed vector table, random run against a rule-level model,
// stall saturation, flush and mid-stall reset sequences.
module tb_issue_scoreboard;

`ifdef SCB_FREE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready;
  logic [2:0]  in_unit;
  logic [5:0]  in_rs1_rn, in_rs2_rn, in_rd_rn, in_rd2_rn;
  logic        in_rs1_use, in_rs2_use, in_rd_we, in_rd2_we;
  logic [4:0]  unit_busy, unit_en;
  logic [5:0]  rd_out_rn, rd2_out_rn;
  logic [11:0] free_rn;
  logic [1:0]  free_en;
  logic        flush;
  logic [63:0] reg_busy;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  issue_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_unit(in_unit), .in_rs1_rn(in_rs1_rn), .in_rs2_rn(in_rs2_rn),
    .in_rs1_use(in_rs1_use), .in_rs2_use(in_rs2_use), .in_rd_rn(in_rd_rn),
    .in_rd2_rn(in_rd2_rn), .in_rd_we(in_rd_we), .in_rd2_we(in_rd2_we),
    .unit_busy(unit_busy), .unit_en(unit_en), .rd_out_rn(rd_out_rn),
    .rd2_out_rn(rd2_out_rn), .free_rn(free_rn), .free_en(free_en),
    .flush(flush), .reg_busy(reg_busy), .stall_cnt(stall_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic idle();
    in_valid = 0; in_unit = 0; in_rs1_rn = 0; in_rs2_rn = 0; in_rs1_use = 0; in_rs2_use = 0;
    in_rd_rn = 0; in_rd2_rn = 0; in_rd_we = 0; in_rd2_we = 0; unit_busy = 0;
    free_rn = 0; free_en = 0; flush = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_unit_en"}, 64'(unit_en), 0);
    check({tag, "_rd_out"}, 64'(rd_out_rn), 0);
    check({tag, "_rd2_out"}, 64'(rd2_out_rn), 0);
    check({tag, "_reg_busy"}, reg_busy, 0);
    check({tag, "_stall"}, 64'(stall_cnt), 0);
  endtask

  typedef struct {
    logic        valid;
    logic [2:0]  unit;
    logic [5:0]  rs1;
    logic        rs1_use;
    logic [5:0]  rd;
    logic        rd_we;
    logic [5:0]  rd2;
    logic        rd2_we;
    logic [4:0]  ubusy;
    logic [5:0]  f0, f1;
    logic [1:0]  fen;
    logic        flush;
    logic        exp_ready;
    logic [4:0]  exp_en;
    logic [5:0]  exp_rd, exp_rd2;
    logic [63:0] exp_busy;
    logic [15:0] exp_stall;
  } vec_t;

  function automatic vec_t v(logic valid, logic [2:0] unit, logic [5:0] rs1, logic rs1_use,
                             logic [5:0] rd, logic rd_we, logic [5:0] rd2, logic rd2_we,
                             logic [4:0] ubusy, logic [5:0] f0, logic [5:0] f1, logic [1:0] fen,
                             logic fl, logic er, logic [4:0] ee, logic [5:0] erd,
                             logic [5:0] erd2, logic [63:0] eb, int es);
    vec_t t;
    t.valid = valid; t.unit = unit; t.rs1 = rs1; t.rs1_use = rs1_use; t.rd = rd; t.rd_we = rd_we;
    t.rd2 = rd2; t.rd2_we = rd2_we; t.ubusy = ubusy; t.f0 = f0; t.f1 = f1; t.fen = fen;
    t.flush = fl; t.exp_ready = er; t.exp_en = ee; t.exp_rd = erd; t.exp_rd2 = erd2;
    t.exp_busy = eb; t.exp_stall = 16'(es);
    return t;
  endfunction

  function automatic logic [63:0] b(int n);
    return 64'd1 << n;
  endfunction

  // scoreboard model state
  bit          mb[64];
  logic [15:0] m_stall;
  logic [5:0]  m_rd, m_rd2;
  logic [96:0] exp_q[$];

  function automatic logic [63:0] model_vec();
    logic [63:0] r = 0;
    for (int i = 1; i < 64; i++) r[i] = mb[i];
    return r;
  endfunction

  function automatic bit model_ready();
    bit haz;
    bit view[64];
    for (int i = 0; i < 64; i++) view[i] = (i != 0) && mb[i];
    if (BYP == 1) begin
      if (free_en[0]) view[free_rn[5:0]] = 0;
      if (free_en[1]) view[free_rn[11:6]] = 0;
    end
    haz = (in_rs1_use && view[in_rs1_rn]) || (in_rs2_use && view[in_rs2_rn]) ||
          (in_rd_we && view[in_rd_rn]) || (in_rd2_we && view[in_rd2_rn]) ||
          (in_unit > 4) || ((in_unit <= 4) && unit_busy[in_unit]) ||
          (in_rd_we && in_rd2_we && in_rd_rn == in_rd2_rn && in_rd_rn != 0);
    return !haz && !flush;
  endfunction

  vec_t tbl[15];

  initial begin
    logic [96:0] e;
    bit rdy;
    bit iss;
    int bud;

    tbl[0]  = v(1,0,0,0, 5,1,0,0, 0,0,0,0,0, 1,5'b00001,5,0,b(5),0);
    tbl[1]  = v(1,1,5,1, 5,0,0,0, 0,0,0,0,0, 0,0,5,0,b(5),1);
    tbl[2]  = v(1,1,5,1, 5,0,0,0, 0,0,0,0,0, 0,0,5,0,b(5),2);
    tbl[3]  = v(1,1,5,1, 5,0,0,0, 0,0,0,0,0, 0,0,5,0,b(5),3);
    tbl[4]  = v(1,1,5,1, 5,0,0,0, 0,0,5,2'b10,0, 1'(BYP),(BYP==1)?5'b00010:5'b0,5,0,0,4-BYP);
    tbl[5]  = v(1,1,5,1, 5,0,0,0, 0,0,0,0,0, 1,5'b00010,5,0,0,4-BYP);
    tbl[6]  = v(1,2,0,0, 6,1,0,0, 5'b00100,0,0,0,0, 0,0,5,0,0,5-BYP);
    tbl[7]  = v(1,3,0,0, 6,1,0,0, 5'b00100,0,0,0,0, 1,5'b01000,6,0,b(6),5-BYP);
    tbl[8]  = v(1,0,0,0, 7,1,0,0, 0,7,6,2'b11,0, 1,5'b00001,7,0,b(7),5-BYP);
    tbl[9]  = v(1,4,0,1, 0,1,0,0, 0,0,0,0,0, 1,5'b10000,0,0,b(7),5-BYP);
    tbl[10] = v(1,0,0,0, 7,1,0,0, 0,0,0,0,0, 0,0,0,0,b(7),6-BYP);
    tbl[11] = v(1,0,0,0, 9,1,9,1, 0,0,0,0,0, 0,0,0,0,b(7),7-BYP);
    tbl[12] = v(1,5,0,0, 12,1,0,0, 0,0,0,0,0, 0,0,0,0,b(7),8-BYP);
    tbl[13] = v(1,0,0,0, 10,1,0,0, 0,0,0,0,1, 0,0,0,0,b(7),8-BYP);
    tbl[14] = v(1,2,0,0, 10,1,11,1, 0,0,0,0,0, 1,5'b00100,10,11,b(7)|b(10)|b(11),8-BYP);

    do_reset();
    check_outputs_zero("reset");

    // directed vector table
    for (int i = 0; i < 15; i++) begin
      in_valid = tbl[i].valid; in_unit = tbl[i].unit; in_rs1_rn = tbl[i].rs1;
      in_rs1_use = tbl[i].rs1_use; in_rs2_rn = 0; in_rs2_use = 0;
      in_rd_rn = tbl[i].rd; in_rd_we = tbl[i].rd_we; in_rd2_rn = tbl[i].rd2;
      in_rd2_we = tbl[i].rd2_we; unit_busy = tbl[i].ubusy;
      free_rn = {tbl[i].f1, tbl[i].f0}; free_en = tbl[i].fen; flush = tbl[i].flush;
      #1;
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].exp_ready));
      cyc();
      check($sformatf("vec%0d_unit_en", i), 64'(unit_en), 64'(tbl[i].exp_en));
      check($sformatf("vec%0d_rd_out", i), 64'(rd_out_rn), 64'(tbl[i].exp_rd));
      check($sformatf("vec%0d_rd2_out", i), 64'(rd2_out_rn), 64'(tbl[i].exp_rd2));
      check($sformatf("vec%0d_reg_busy", i), reg_busy, tbl[i].exp_busy);
      check($sformatf("vec%0d_stall", i), 64'(stall_cnt), 64'(tbl[i].exp_stall));
    end

    // random run against the rule-level model
    do_reset();
    for (int i = 0; i < 64; i++) mb[i] = 0;
    m_stall = 0; m_rd = 0; m_rd2 = 0;
    for (int n = 0; n < 600; n++) begin
      in_valid   = 1'($urandom_range(0, 3) != 0);
      in_unit    = 3'($urandom_range(0, 7));
      in_rs1_rn  = 6'($urandom_range(0, 7));
      in_rs2_rn  = 6'($urandom_range(0, 7));
      in_rs1_use = 1'($urandom_range(0, 1));
      in_rs2_use = 1'($urandom_range(0, 1));
      in_rd_rn   = 6'($urandom_range(0, 7));
      in_rd2_rn  = 6'($urandom_range(0, 7));
      in_rd_we   = 1'($urandom_range(0, 1));
      in_rd2_we  = 1'($urandom_range(0, 1));
      unit_busy  = 5'($urandom_range(0, 31) & $urandom_range(0, 31));
      free_rn    = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      free_en    = 2'($urandom_range(0, 3));
      flush      = 1'($urandom_range(0, 15) == 0);
      #1;
      rdy = model_ready();
      check("rand_in_ready", 64'(in_ready), 64'(rdy));
      iss = in_valid && rdy;
      if (free_en[0]) mb[free_rn[5:0]] = 0;
      if (free_en[1]) mb[free_rn[11:6]] = 0;
      if (iss && in_rd_we && in_rd_rn != 0) mb[in_rd_rn] = 1;
      if (iss && in_rd2_we && in_rd2_rn != 0) mb[in_rd2_rn] = 1;
      if (iss) begin m_rd = in_rd_rn; m_rd2 = in_rd2_rn; end
      if (in_valid && !rdy && !flush && m_stall != 16'hFFFF) m_stall++;
      exp_q.push_back({(iss ? 5'(1 << in_unit) : 5'b0), m_rd, m_rd2, model_vec(), m_stall});
      cyc();
      e = exp_q.pop_front();
      check("rand_unit_en", 64'(unit_en), 64'(e[96:92]));
      check("rand_rd_out", 64'(rd_out_rn), 64'(e[91:86]));
      check("rand_rd2_out", 64'(rd2_out_rn), 64'(e[85:80]));
      check("rand_reg_busy", reg_busy, e[79:16]);
      check("rand_stall", 64'(stall_cnt), 64'(e[15:0]));
    end

    // stall saturation
    do_reset();
    idle();
    in_valid = 1; in_rd_rn = 5; in_rd_we = 1;
    cyc();
    check("sat_setup_busy", reg_busy, b(5));
    idle();
    in_valid = 1; in_unit = 1; in_rs1_rn = 5; in_rs1_use = 1;
    bud = (1 << 16) + 5;
    for (int i = 0; i < bud; i++) cyc();
    check("sat_stall", 64'(stall_cnt), 64'hFFFF);
    check("sat_ready", 64'(in_ready), 0);

    // flush with an otherwise issuable instruction
    in_rs1_use = 0; in_rd_rn = 20; in_rd_we = 1; flush = 1;
    #1;
    check("flush_ready", 64'(in_ready), 0);
    cyc();
    check("flush_unit_en", 64'(unit_en), 0);
    check("flush_stall", 64'(stall_cnt), 64'hFFFF);
    check("flush_busy", reg_busy, b(5));

    // reset mid-stall
    flush = 0; in_rs1_use = 1; in_rd_we = 0;
    cyc();
    #3;
    rst_n = 0;
    #1;
    check_outputs_zero("midrst");
    cyc();
    check_outputs_zero("midrst_hold");
    rst_n = 1;
    idle();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
